// File: rtl/jac_to_affine_pkg.sv
// Shared definitions for the Jacobian-to-affine converter: default width,
// FSM state encodings and the multiplier operand-select type.
package ecc_pkg;

  localparam int ECC_WIDTH = 256;
  localparam int ONE       = 1;

  // FSM state encodings (plain constants so older tools and checkers can bind to them)
  typedef logic [3:0] jta_state_t;
  localparam jta_state_t ST_IDLE = 4'd0;
  localparam jta_state_t ST_ZCHK = 4'd1;
  localparam jta_state_t ST_SQ   = 4'd2;
  localparam jta_state_t ST_MUL  = 4'd3;
  localparam jta_state_t ST_ZI2  = 4'd4;
  localparam jta_state_t ST_ZI3  = 4'd5;
  localparam jta_state_t ST_MX   = 4'd6;
  localparam jta_state_t ST_MY   = 4'd7;
  localparam jta_state_t ST_DONE = 4'd8;

  // Which operand pair the shared multiplier sees
  typedef enum logic [2:0] {
    OP_SQ, OP_MUL, OP_ZI2, OP_ZI3, OP_MX, OP_MY, OP_NONE
  } mul_op_t;

  function automatic mul_op_t state_op(input jta_state_t s);
    case (s)
      ST_SQ:   return OP_SQ;
      ST_MUL:  return OP_MUL;
      ST_ZI2:  return OP_ZI2;
      ST_ZI3:  return OP_ZI3;
      ST_MX:   return OP_MX;
      ST_MY:   return OP_MY;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/jac_to_affine_if.sv
// Request/result bundle of the Jacobian-to-affine converter.
// Handshake: i_start is a one-cycle pulse taken only while the block is idle;
// X1/Y1/Z1/p are sampled on that same edge. o_busy covers the cycle after the
// accepted start through the o_done cycle; o_done is a one-cycle pulse and
// X_aff/Y_aff/o_inf are valid with it and held until the next accepted start.
interface jac_to_affine_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] Y1;
  logic [WIDTH-1:0] Z1;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] X_aff;
  logic [WIDTH-1:0] Y_aff;
  logic             o_inf;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, X1, Y1, Z1, p,
    input  X_aff, Y_aff, o_inf, o_busy, o_done
  );

  modport slave (
    input  i_start, X1, Y1, Z1, p,
    output X_aff, Y_aff, o_inf, o_busy, o_done
  );
endinterface

// File: rtl/jac_to_affine_mont_final.sv
// Digit-serial modular multiplier m = a*b mod p (a, b < p, p odd).
// Scans b MSB-first, DIGIT bits per cycle: WIDTH/DIGIT iteration cycles.
// done drops on the edge that samples start and rises with the result.
module mont_final #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] m
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0] a_r, b_r, p_r, r, r_next;
  logic [CW-1:0]    cnt;
  logic             busy;

  // r <- (2^DIGIT * r + a * digit) mod p, one bit at a time; 2r + a < 3p
  // so two conditional subtractions keep each step fully reduced.
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] rr,
    input logic [WIDTH-1:0] aa,
    input logic [WIDTH-1:0] pp,
    input logic [DIGIT-1:0] bits
  );
    logic [WIDTH+1:0] t;
    t = {2'b00, rr};
    for (int i = DIGIT - 1; i >= 0; i--) begin
      t = {t[WIDTH:0], 1'b0} + (bits[i] ? {2'b00, aa} : '0);
      if (t >= {2'b00, pp}) t = t - {2'b00, pp};
      if (t >= {2'b00, pp}) t = t - {2'b00, pp};
    end
    return t[WIDTH-1:0];
  endfunction

  // Next partial product from the current top digit of b
  always_comb begin
    r_next = step(r, a_r, p_r, b_r[WIDTH-1 -: DIGIT]);
  end

  // Operand latch, digit iteration and completion flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      p_r  <= '0;
      r    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      a_r  <= a;
      b_r  <= b;
      p_r  <= p;
      r    <= '0;
      cnt  <= CW'(STEPS);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      r   <= r_next;
      b_r <= {b_r[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign m = r;

endmodule

// File: rtl/jac_to_affine.sv
// Jacobian (X,Y,Z) -> affine (X/Z^2, Y/Z^3) mod p. Z^-1 = Z^(p-2) by a
// fixed-length square-and-always-multiply scan, then four finishing products,
// all through one shared mont_final.
module jac_to_affine
  import ecc_pkg::*;
#(
  parameter int WIDTH     = ECC_WIDTH,
  parameter int EXP_BITS  = 256,
  parameter int MUL_DIGIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  jac_to_affine_if.slave  bus,
  output jta_state_t      dbg_state
);

  localparam int            KW    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [KW-1:0] K_MAX = KW'(EXP_BITS - 1);

  // Multiply sub-phase: issue start, skip the stale-done cycle, wait for done
  localparam logic [1:0] PH_ISSUE = 2'd0;
  localparam logic [1:0] PH_SKIP  = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  jta_state_t       state;
  logic [1:0]       phase;
  logic [WIDTH-1:0] x_r, y_r, z_r, p_r, e_r;
  logic [WIDTH-1:0] acc, zi2, zi3;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] x_aff, y_aff;
  logic             inf_r, busy_r, done_r;

  mul_op_t          op;
  logic [WIDTH-1:0] mul_a, mul_b, mul_m;
  logic             mul_start, mul_done;

  // Operand selection for the shared multiplier
  always_comb begin
    op    = state_op(state);
    mul_a = '0;
    mul_b = '0;
    case (op)
      OP_SQ:   begin mul_a = acc; mul_b = acc; end
      OP_MUL:  begin mul_a = acc; mul_b = z_r; end
      OP_ZI2:  begin mul_a = acc; mul_b = acc; end
      OP_ZI3:  begin mul_a = zi2; mul_b = acc; end
      OP_MX:   begin mul_a = x_r; mul_b = zi2; end
      OP_MY:   begin mul_a = y_r; mul_b = zi3; end
      default: begin mul_a = '0;  mul_b = '0;  end
    endcase
    mul_start = (op != OP_NONE) && (phase == PH_ISSUE);
  end

  mont_final #(
    .WIDTH (WIDTH),
    .DIGIT (MUL_DIGIT)
  ) u_mul (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .p     (p_r),
    .done  (mul_done),
    .m     (mul_m)
  );

  // Control FSM, operand registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      phase  <= PH_ISSUE;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      p_r    <= '0;
      e_r    <= '0;
      acc    <= '0;
      zi2    <= '0;
      zi3    <= '0;
      k      <= '0;
      x_aff  <= '0;
      y_aff  <= '0;
      inf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            x_r    <= bus.X1;
            y_r    <= bus.Y1;
            z_r    <= bus.Z1;
            p_r    <= bus.p;
            e_r    <= bus.p - WIDTH'(2);
            busy_r <= 1'b1;
            state  <= ST_ZCHK;
          end
        end
        ST_ZCHK: begin
          if (z_r == '0) begin
            inf_r  <= 1'b1;
            x_aff  <= '0;
            y_aff  <= '0;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else begin
            acc   <= WIDTH'(ONE);
            k     <= K_MAX;
            phase <= PH_ISSUE;
            state <= ST_SQ;
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          case (phase)
            PH_ISSUE: phase <= PH_SKIP;
            PH_SKIP:  phase <= PH_WAIT;
            default: begin
              if (mul_done) begin
                phase <= PH_ISSUE;
                case (state)
                  ST_SQ: begin
                    acc   <= mul_m;
                    state <= ST_MUL;
                  end
                  ST_MUL: begin
                    if (e_r[k]) acc <= mul_m;
                    if (k == '0) begin
                      state <= ST_ZI2;
                    end else begin
                      k     <= k - KW'(1);
                      state <= ST_SQ;
                    end
                  end
                  ST_ZI2: begin
                    zi2   <= mul_m;
                    state <= ST_ZI3;
                  end
                  ST_ZI3: begin
                    zi3   <= mul_m;
                    state <= ST_MX;
                  end
                  ST_MX: begin
                    x_aff <= mul_m;
                    state <= ST_MY;
                  end
                  ST_MY: begin
                    y_aff  <= mul_m;
                    inf_r  <= 1'b0;
                    done_r <= 1'b1;
                    state  <= ST_DONE;
                  end
                  default: state <= ST_IDLE;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  assign bus.X_aff  = x_aff;
  assign bus.Y_aff  = y_aff;
  assign bus.o_inf  = inf_r;
  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;
  assign dbg_state  = state;

endmodule

// File: tb/tb_jac_to_affine.sv
// Directed bench: small 8-bit instance for table vectors and corner
// sequences, full 256-bit instance for the P-256 generator case.
module tb_jac_to_affine;
  import ecc_pkg::*;

  localparam int LAT_S = (2 * 8 + 4) * (8 / 2 + 2) + 3;       // 123
  localparam int LAT_L = (2 * 256 + 4) * (256 / 4 + 2) + 3;   // 34059
  localparam int BUDGET_S = 400;
  localparam int BUDGET_L = 40000;

  logic       clk;
  logic       rst_n;
  jta_state_t st_s, st_l;

  jac_to_affine_if #(.WIDTH(8))   bus_s ();
  jac_to_affine_if #(.WIDTH(256)) bus_l ();

  jac_to_affine #(.WIDTH(8), .EXP_BITS(8), .MUL_DIGIT(2)) dut_s (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus_s),
    .dbg_state (st_s)
  );

  jac_to_affine #(.WIDTH(256), .EXP_BITS(256), .MUL_DIGIT(4)) dut_l (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus_l),
    .dbg_state (st_l)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected values are pushed, then popped against actuals
  logic [255:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act);
    logic [255:0] exp_v;
    exp_v = exp_q.pop_front();
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [7:0] x, y, z, p;
    logic [7:0] ex, ey;
    logic       einf;
  } vec_t;

  vec_t vecs[8];

  // Driver: one small-instance operation, optionally poking start/inputs mid-run
  task automatic run_small(input logic [7:0] x, y, z, pm, input bit poke,
                           output int lat, output bit busy_ok);
    @(negedge clk);
    bus_s.X1 = x; bus_s.Y1 = y; bus_s.Z1 = z; bus_s.p = pm;
    bus_s.i_start = 1'b1;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    lat = 2;
    busy_ok = 1'b1;
    while (bus_s.o_done !== 1'b1 && lat < BUDGET_S) begin
      if (bus_s.o_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
      if (poke && lat == 10) begin
        bus_s.X1 = 8'($urandom_range(0, 255));
        bus_s.Y1 = 8'($urandom_range(0, 255));
        bus_s.Z1 = 8'($urandom_range(0, 255));
        bus_s.p  = 8'd13;
        bus_s.i_start = 1'b1;
      end
      if (poke && lat == 11) bus_s.i_start = 1'b0;
    end
    if (bus_s.o_busy !== 1'b1) busy_ok = 1'b0;
  endtask

  // Post-op: done is a single pulse and busy has dropped
  task automatic check_after(input string tag);
    @(negedge clk);
    exp_q.push_back(256'd0); check({tag, " done_pulse"}, {255'd0, bus_s.o_done});
    exp_q.push_back(256'd0); check({tag, " busy_drop"},  {255'd0, bus_s.o_busy});
  endtask

  initial begin
    int  lat;
    bit  bok;
    int  n_done;
    int  wait_n;

    vecs[0] = '{x: 8'd12,  y: 8'd11,  z: 8'd2,  p: 8'd23,  ex: 8'd3,  ey: 8'd10, einf: 1'b0};
    vecs[1] = '{x: 8'd5,   y: 8'd7,   z: 8'd1,  p: 8'd23,  ex: 8'd5,  ey: 8'd7,  einf: 1'b0};
    vecs[2] = '{x: 8'd4,   y: 8'd5,   z: 8'd3,  p: 8'd23,  ex: 8'd3,  ey: 8'd7,  einf: 1'b0};
    vecs[3] = '{x: 8'd10,  y: 8'd9,   z: 8'd22, p: 8'd23,  ex: 8'd10, ey: 8'd14, einf: 1'b0};
    vecs[4] = '{x: 8'd100, y: 8'd200, z: 8'd2,  p: 8'd251, ex: 8'd25, ey: 8'd25, einf: 1'b0};
    vecs[5] = '{x: 8'd0,   y: 8'd12,  z: 8'd5,  p: 8'd13,  ex: 8'd0,  ey: 8'd8,  einf: 1'b0};
    vecs[6] = '{x: 8'd22,  y: 8'd22,  z: 8'd2,  p: 8'd23,  ex: 8'd17, ey: 8'd20, einf: 1'b0};
    vecs[7] = '{x: 8'd9,   y: 8'd4,   z: 8'd0,  p: 8'd23,  ex: 8'd0,  ey: 8'd0,  einf: 1'b1};

    rst_n = 1'b0;
    bus_s.i_start = 1'b0; bus_s.X1 = '0; bus_s.Y1 = '0; bus_s.Z1 = '0; bus_s.p = '0;
    bus_l.i_start = 1'b0; bus_l.X1 = '0; bus_l.Y1 = '0; bus_l.Z1 = '0; bus_l.p = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    exp_q.push_back(256'd0); check("rst X_aff", {248'd0, bus_s.X_aff});
    exp_q.push_back(256'd0); check("rst Y_aff", {248'd0, bus_s.Y_aff});
    exp_q.push_back(256'd0); check("rst o_inf", {255'd0, bus_s.o_inf});
    exp_q.push_back(256'd0); check("rst o_busy", {255'd0, bus_s.o_busy});
    exp_q.push_back(256'd0); check("rst o_done", {255'd0, bus_s.o_done});
    exp_q.push_back(256'(ST_IDLE)); check("rst state", {252'd0, st_s});
    exp_q.push_back(256'd0); check("rst large X_aff", bus_l.X_aff);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_small(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].p, 1'b0, lat, bok);
      exp_q.push_back({248'd0, vecs[i].ex}); check($sformatf("vec%0d X_aff", i), {248'd0, bus_s.X_aff});
      exp_q.push_back({248'd0, vecs[i].ey}); check($sformatf("vec%0d Y_aff", i), {248'd0, bus_s.Y_aff});
      exp_q.push_back({255'd0, vecs[i].einf}); check($sformatf("vec%0d o_inf", i), {255'd0, bus_s.o_inf});
      exp_q.push_back(256'(vecs[i].einf ? 3 : LAT_S)); check($sformatf("vec%0d latency", i), 256'(lat));
      exp_q.push_back(256'd1); check($sformatf("vec%0d busy_throughout", i), {255'd0, bok});
      check_after($sformatf("vec%0d", i));
    end

    // Start while busy with inputs changed mid-run: original inputs win
    run_small(8'd12, 8'd11, 8'd2, 8'd23, 1'b1, lat, bok);
    exp_q.push_back(256'd3);  check("busy_restart X_aff", {248'd0, bus_s.X_aff});
    exp_q.push_back(256'd10); check("busy_restart Y_aff", {248'd0, bus_s.Y_aff});
    exp_q.push_back(256'(LAT_S)); check("busy_restart latency", 256'(lat));
    check_after("busy_restart");

    // One-cycle reset in the middle of the SQ phase
    @(negedge clk);
    bus_s.X1 = 8'd12; bus_s.Y1 = 8'd11; bus_s.Z1 = 8'd2; bus_s.p = 8'd23;
    bus_s.i_start = 1'b1;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    wait_n = 0;
    while (st_s !== ST_SQ && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    exp_q.push_back(256'(ST_SQ)); check("midrun reached SQ", {252'd0, st_s});
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(256'd0); check("midrst X_aff", {248'd0, bus_s.X_aff});
    exp_q.push_back(256'd0); check("midrst Y_aff", {248'd0, bus_s.Y_aff});
    exp_q.push_back(256'd0); check("midrst o_busy", {255'd0, bus_s.o_busy});
    exp_q.push_back(256'(ST_IDLE)); check("midrst state", {252'd0, st_s});
    n_done = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (bus_s.o_done === 1'b1) n_done++;
    end
    exp_q.push_back(256'd0); check("midrst no_done", 256'(n_done));
    run_small(8'd12, 8'd11, 8'd2, 8'd23, 1'b0, lat, bok);
    exp_q.push_back(256'd3);  check("post_rst X_aff", {248'd0, bus_s.X_aff});
    exp_q.push_back(256'd10); check("post_rst Y_aff", {248'd0, bus_s.Y_aff});
    exp_q.push_back(256'(LAT_S)); check("post_rst latency", 256'(lat));

    // P-256 generator with Z = 1
    @(negedge clk);
    bus_l.p  = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    bus_l.X1 = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    bus_l.Y1 = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;
    bus_l.Z1 = 256'd1;
    bus_l.i_start = 1'b1;
    @(negedge clk);
    bus_l.i_start = 1'b0;
    lat = 2;
    while (bus_l.o_done !== 1'b1 && lat < BUDGET_L) begin
      @(negedge clk);
      lat++;
    end
    exp_q.push_back(256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296);
    check("p256 X_aff", bus_l.X_aff);
    exp_q.push_back(256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5);
    check("p256 Y_aff", bus_l.Y_aff);
    exp_q.push_back(256'd0); check("p256 o_inf", {255'd0, bus_l.o_inf});
    exp_q.push_back(256'(LAT_L)); check("p256 latency", 256'(lat));

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
